// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction and data requesters
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } state_t;

    localparam logic [1:0] ACCESS = 2'd2;

    state_t      state;
    state_t      next_state;
    logic [2:0]  starve_cnt;
    logic [2:0]  next_cnt;
    logic        dreq;
    logic        access;
    logic        starve_hit;

    assign dreq       = dREN | dWEN;
    assign access     = (ramstate == ACCESS);
    assign starve_hit = ({29'd0, starve_cnt} >= STARVE_LIMIT);

    // Asynchronous reset forces IDLE immediately, which zeroes every RAM strobe in the same cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = starve_cnt;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'd0;
        ramstore   = 32'd0;
        iload      = 32'd0;
        dload      = 32'd0;
        iwait      = iREN;
        dwait      = dreq;

        case (state)
            IDLE: begin
                if (dreq && iREN && starve_hit) begin
                    next_state = IGRANT;
                end else if (dreq) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~access;
                if (access) begin
                    dload = ramload;
                end
                // ERROR and BUSY both leave the grant in place; only ACCESS or a dropped request ends it.
                if (!dreq) begin
                    next_state = IDLE;
                end else if (access) begin
                    next_state = IDLE;
                    if (iREN && starve_cnt != 3'd7) begin
                        next_cnt = starve_cnt + 3'd1;
                    end
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~access;
                if (access) begin
                    iload = ramload;
                end
                if (!iREN) begin
                    next_state = IDLE;
                end else if (access) begin
                    next_state = IDLE;
                    next_cnt   = 3'd0;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = 32'd0;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dstore = 32'd0;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = 32'd0;
    logic [1:0]  ramstate = 2'd0;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the RAM port (0 none, 1 data, 2 instruction) and how many data grants starved iREN.
    int m_owner = 0;
    int m_cnt   = 0;
    logic dreq;
    assign dreq = dREN | dWEN;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner <= 0;
            m_cnt   <= 0;
        end else if (m_owner == 0) begin
            if (dreq && iREN && m_cnt >= LIMIT) m_owner <= 2;
            else if (dreq)                      m_owner <= 1;
            else if (iREN)                      m_owner <= 2;
        end else if (m_owner == 1) begin
            if (!dreq) m_owner <= 0;
            else if (ramstate == 2'd2) begin
                m_owner <= 0;
                if (iREN) m_cnt <= (m_cnt + 1 > 7) ? 7 : m_cnt + 1;
            end
        end else begin
            if (!iREN) m_owner <= 0;
            else if (ramstate == 2'd2) begin
                m_owner <= 0;
                m_cnt   <= 0;
            end
        end
    end

    logic [31:0] e_addr, e_store, e_iload, e_dload;
    logic        e_ren, e_wen, e_iwait, e_dwait;

    always_comb begin
        e_addr  = 32'd0;
        e_store = 32'd0;
        e_iload = 32'd0;
        e_dload = 32'd0;
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_iwait = iREN;
        e_dwait = dreq;
        if (m_owner == 1) begin
            e_addr  = daddr;
            e_store = dstore;
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            e_dwait = (ramstate != 2'd2);
            e_dload = (ramstate == 2'd2) ? ramload : 32'd0;
        end else if (m_owner == 2) begin
            e_addr  = iaddr;
            e_ren   = iREN;
            e_iwait = (ramstate != 2'd2);
            e_iload = (ramstate == 2'd2) ? ramload : 32'd0;
        end
    end

    always @(negedge CLK) begin
        chk("cmp_ramaddr", ramaddr, e_addr);
        chk("cmp_ramstore", ramstore, e_store);
        chk("cmp_ramREN", {31'd0, ramREN}, {31'd0, e_ren});
        chk("cmp_ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
        chk("cmp_iwait", {31'd0, iwait}, {31'd0, e_iwait});
        chk("cmp_dwait", {31'd0, dwait}, {31'd0, e_dwait});
        chk("cmp_iload", iload, e_iload);
        chk("cmp_dload", dload, e_dload);
        chk("cmp_starve", {29'd0, dut.starve_cnt}, 32'(m_cnt));
    end

    task automatic next_cycle();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        // Reset state, with iREN asserted so iwait must follow it.
        iREN = 1'b1;
        #2;
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd0);
        chk("rst_starve", {29'd0, dut.starve_cnt}, 32'd0);
        next_cycle();
        nRST = 1'b1;

        // Instruction fetch: BUSY twice then ACCESS.
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1; #1;
        chk("f_idle_ren", {31'd0, ramREN}, 32'd0);
        chk("f_idle_iwait", {31'd0, iwait}, 32'd1);
        next_cycle();
        #1;
        chk("f_b1_ren", {31'd0, ramREN}, 32'd1);
        chk("f_b1_addr", ramaddr, 32'h40);
        chk("f_b1_iwait", {31'd0, iwait}, 32'd1);
        next_cycle();
        #1;
        chk("f_b2_iwait", {31'd0, iwait}, 32'd1);
        next_cycle();
        ramstate = 2'd2; ramload = 32'hDEADBEEF; #1;
        chk("f_acc_iwait", {31'd0, iwait}, 32'd0);
        chk("f_acc_iload", iload, 32'hDEADBEEF);
        next_cycle();
        ramstate = 2'd0; #1;
        chk("f_idle2_ren", {31'd0, ramREN}, 32'd0);
        chk("f_idle2_iwait", {31'd0, iwait}, 32'd1);
        chk("f_idle2_iload", iload, 32'd0);
        next_cycle();
        iREN = 1'b0; #1;
        chk("f_drop_ren", {31'd0, ramREN}, 32'd0);
        next_cycle();

        // Simultaneous write and fetch: data first, then instruction.
        dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h5; iREN = 1'b1; iaddr = 32'h80; #1;
        chk("c_idle_dwait", {31'd0, dwait}, 32'd1);
        next_cycle();
        ramstate = 2'd1; #1;
        chk("c_d_wen", {31'd0, ramWEN}, 32'd1);
        chk("c_d_addr", ramaddr, 32'h3100);
        chk("c_d_store", ramstore, 32'h5);
        chk("c_d_iwait", {31'd0, iwait}, 32'd1);
        next_cycle();
        ramstate = 2'd2; #1;
        chk("c_d_acc_dwait", {31'd0, dwait}, 32'd0);
        chk("c_d_acc_iwait", {31'd0, iwait}, 32'd1);
        next_cycle();
        dWEN = 1'b0; ramstate = 2'd0; #1;
        chk("c_idle_iwait", {31'd0, iwait}, 32'd1);
        chk("c_idle_starve", {29'd0, dut.starve_cnt}, 32'd1);
        next_cycle();
        ramstate = 2'd1; #1;
        chk("c_i_ren", {31'd0, ramREN}, 32'd1);
        chk("c_i_addr", ramaddr, 32'h80);
        chk("c_i_store", ramstore, 32'd0);
        next_cycle();
        ramstate = 2'd2; ramload = 32'h1234; #1;
        chk("c_i_iload", iload, 32'h1234);
        next_cycle();
        iREN = 1'b0; ramstate = 2'd0; #1;
        chk("c_end_starve", {29'd0, dut.starve_cnt}, 32'd0);
        next_cycle();

        // Starvation: four data grants, then the instruction port wins.
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h100;
        for (int g = 0; g < 4; g++) begin
            ramstate = 2'd0; #1;
            chk("s_idle_ren", {31'd0, ramREN}, 32'd0);
            next_cycle();
            ramstate = 2'd2; ramload = 32'hA0 + 32'(g); #1;
            chk("s_d_addr", ramaddr, 32'h200);
            chk("s_d_dload", dload, 32'hA0 + 32'(g));
            chk("s_d_iwait", {31'd0, iwait}, 32'd1);
            chk("s_d_starve", {29'd0, dut.starve_cnt}, 32'(g));
            next_cycle();
        end
        ramstate = 2'd0; #1;
        chk("s_idle_starve4", {29'd0, dut.starve_cnt}, 32'd4);
        next_cycle();
        ramstate = 2'd2; ramload = 32'hBB; #1;
        chk("s_i_addr", ramaddr, 32'h100);
        chk("s_i_iload", iload, 32'hBB);
        chk("s_i_dwait", {31'd0, dwait}, 32'd1);
        next_cycle();
        dREN = 1'b0; iREN = 1'b0; ramstate = 2'd0; #1;
        chk("s_end_starve", {29'd0, dut.starve_cnt}, 32'd0);
        next_cycle();

        // Read and write together: write wins.
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h44;
        next_cycle();
        ramstate = 2'd1; #1;
        chk("rw_wen", {31'd0, ramWEN}, 32'd1);
        chk("rw_ren", {31'd0, ramREN}, 32'd0);
        next_cycle();
        ramstate = 2'd2; #1;
        chk("rw_dwait", {31'd0, dwait}, 32'd0);
        next_cycle();
        dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0; #1;
        chk("rw_starve", {29'd0, dut.starve_cnt}, 32'd0);
        next_cycle();

        // ERROR retries keep the grant and the stall.
        dREN = 1'b1; daddr = 32'h300;
        next_cycle();
        for (int e = 0; e < 3; e++) begin
            ramstate = 2'd3; #1;
            chk("e_dwait", {31'd0, dwait}, 32'd1);
            chk("e_ren", {31'd0, ramREN}, 32'd1);
            chk("e_addr", ramaddr, 32'h300);
            next_cycle();
        end
        ramstate = 2'd2; #1;
        chk("e_acc_dwait", {31'd0, dwait}, 32'd0);
        next_cycle();
        dREN = 1'b0; ramstate = 2'd0; #1;
        chk("e_idle_ren", {31'd0, ramREN}, 32'd0);
        next_cycle();

        // Reset pulse mid-grant after the starve counter has moved.
        dREN = 1'b1; iREN = 1'b1;
        next_cycle();
        ramstate = 2'd2;
        next_cycle();
        iREN = 1'b0; ramstate = 2'd0; #1;
        chk("r_pre_starve", {29'd0, dut.starve_cnt}, 32'd1);
        next_cycle();
        ramstate = 2'd1; #1;
        chk("r_busy_ren", {31'd0, ramREN}, 32'd1);
        nRST = 1'b0; #1;
        chk("r_rst_ren", {31'd0, ramREN}, 32'd0);
        chk("r_rst_wen", {31'd0, ramWEN}, 32'd0);
        chk("r_rst_addr", ramaddr, 32'd0);
        chk("r_rst_dwait", {31'd0, dwait}, 32'd1);
        chk("r_rst_starve", {29'd0, dut.starve_cnt}, 32'd0);
        nRST = 1'b1;
        next_cycle();
        dREN = 1'b0; ramstate = 2'd0; #1;
        chk("r_drop_ren", {31'd0, ramREN}, 32'd0);
        next_cycle();

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            int rs;
            if (m_owner == 0) begin
                iREN = ($urandom_range(0, 2) != 0);
                dREN = ($urandom_range(0, 1) != 0);
                dWEN = ($urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 19) == 0) begin
                if (m_owner == 1) begin
                    dREN = 1'b0;
                    dWEN = 1'b0;
                end else begin
                    iREN = 1'b0;
                end
            end
            rs = int'($urandom_range(0, 9));
            ramstate = (rs < 2) ? 2'd0 : (rs < 5) ? 2'd1 : (rs < 8) ? 2'd2 : 2'd3;
            iaddr   = $urandom;
            daddr   = $urandom;
            dstore  = $urandom;
            ramload = $urandom;
            if ($urandom_range(0, 149) == 0) begin
                #1 nRST = 1'b0;
                #1 nRST = 1'b1;
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the count of consecutive data grants after which a pending instruction request wins.
REQ-002 SHALL have input CLK, 1 bit: rising-edge clock.
REQ-003 SHALL have input nRST, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have inputs iREN (1 bit) and iaddr (32 bits): instruction read request.
REQ-005 SHALL have outputs iload (32 bits) and iwait (1 bit): instruction read data and stall.
REQ-006 SHALL have inputs dREN (1 bit), dWEN (1 bit), daddr (32 bits) and dstore (32 bits): data request.
REQ-007 SHALL have outputs dload (32 bits) and dwait (1 bit): data read data and stall.
REQ-008 SHALL have outputs ramREN (1 bit), ramWEN (1 bit), ramaddr (32 bits) and ramstore (32 bits): single RAM port.
REQ-009 SHALL have inputs ramload (32 bits) and ramstate (2 bits), where ramstate encodes FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-010 SHALL implement FSM states IDLE, DGRANT and IGRANT, with the current owner held in a register.
REQ-011 In IDLE with a data request (dREN|dWEN) and no instruction request, the FSM SHALL move to DGRANT on the next edge.
REQ-012 In IDLE with only iREN asserted, the FSM SHALL move to IGRANT.
REQ-013 In IDLE with both requests asserted, the FSM SHALL choose DGRANT, unless starve_cnt >= STARVE_LIMIT, in which case it SHALL choose IGRANT.
REQ-014 In IDLE, all RAM outputs SHALL be 0, iwait SHALL equal iREN, and dwait SHALL equal (dREN|dWEN).
REQ-015 In DGRANT, ramaddr SHALL equal daddr, ramstore SHALL equal dstore, ramREN SHALL equal dREN, and ramWEN SHALL equal dWEN.
REQ-016 In DGRANT, if dREN and dWEN are both 1, ramWEN SHALL win and ramREN SHALL be 0.
REQ-017 In IGRANT, ramaddr SHALL equal iaddr, ramREN SHALL be 1, ramWEN SHALL be 0, and ramstore SHALL be 0.
REQ-018 In a grant state, the owner's wait output SHALL be 0 only in the cycle where ramstate==ACCESS, and SHALL be 1 otherwise.
REQ-019 The non-owner's wait output SHALL be held at 1 whenever its request is asserted.
REQ-020 iload and dload SHALL carry ramload combinationally when ramstate==ACCESS and the port is owner, and SHALL be 0 otherwise.
REQ-021 The FSM SHALL return to IDLE on the edge after an ACCESS cycle; there is no back-to-back grant without passing through IDLE (1 idle cycle minimum between transactions).
REQ-022 If the owner drops its request while in a grant state, the FSM SHALL return to IDLE next edge and drive no RAM strobe in that cycle.
REQ-023 On ramstate==ERROR in a grant state, the owner's wait SHALL be held at 1 and the FSM SHALL stay in that state, retrying until ACCESS.
REQ-024 starve_cnt (3 bits, saturating at 7) SHALL increment when a DGRANT completes with iREN asserted.
REQ-025 starve_cnt SHALL clear to 0 when an IGRANT completes.
REQ-026 starve_cnt SHALL be unchanged when a DGRANT completes with iREN low.
REQ-027 Request inputs SHALL be treated as stable for the duration of a grant, and the address is not latched.

Reset
REQ-028 While nRST=0, the state SHALL be IDLE, starve_cnt SHALL be 0, and all RAM outputs and iload/dload SHALL be 0.
REQ-029 While nRST=0, iwait and dwait SHALL follow REQ-014 combinationally.
REQ-030 Reset asserted mid-grant SHALL abort the transaction immediately and force ramREN=ramWEN=0 in the same cycle.

Verification
REQ-031 Bench SHALL cover: iREN=1, iaddr=0x40, RAM BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF -> iwait falls for exactly 1 cycle, iload=0xDEADBEEF, then IDLE.
REQ-032 Bench SHALL cover: dWEN=1 and iREN=1 together, daddr=0x3100, dstore=0x5 -> DGRANT first with ramWEN=1, ramaddr=0x3100, iwait=1 throughout, then IGRANT.
REQ-033 Bench SHALL cover: dREN held continuously with iREN=1, STARVE_LIMIT=4 -> 4 data grants, then an IGRANT, then starve_cnt=0.
REQ-034 Bench SHALL cover: dREN=dWEN=1 -> ramWEN=1 and ramREN=0.
REQ-035 Bench SHALL cover: ramstate=ERROR for 3 cycles during DGRANT, then ACCESS -> dwait=1 for all ERROR cycles and falls only on ACCESS.
REQ-036 Bench SHALL cover: nRST pulsed low during a BUSY cycle of DGRANT -> RAM strobes 0 in that cycle, state IDLE, starve_cnt=0.
